// File: rtl/add_pkg.sv
// Shared definitions for the adder family: controller state encoding and default width.
package add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int ADD_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, shared with the ripple adder.
module full_adder (
   input  logic A,
   input  logic B,
   input  logic C_in,
   output logic Sum,
   output logic C_out
);

   assign Sum   = A ^ B ^ C_in;
   assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full_adder cell is reused over WIDTH cycles to form a + b + c_in.
// Handshake: start is accepted on a rising edge in IDLE or DONE; busy marks RUN; done pulses once with sum/c_out.
module serial_add_ctrl
   import add_pkg::*;
#(
   parameter int WIDTH = ADD_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output state_e           dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_e             state_q;
   logic [WIDTH-1:0]   a_sr_q;
   logic [WIDTH-1:0]   b_sr_q;
   logic [WIDTH-1:0]   res_sr_q;
   logic [WIDTH-1:0]   res_d;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   sum_q;
   logic               c_out_q;
   logic               fa_sum;
   logic               fa_cout;

   full_adder u_fa (
      .A     (a_sr_q[0]),
      .B     (b_sr_q[0]),
      .C_in  (carry_q),
      .Sum   (fa_sum),
      .C_out (fa_cout)
   );

   // Result bits enter at the MSB so the LSB computed first ends up in bit 0.
   generate
      if (WIDTH == 1) begin : g_res_w1
         assign res_d = fa_sum;
      end else begin : g_res_wn
         assign res_d = {fa_sum, res_sr_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         sum_q    <= '0;
         c_out_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_sr_q  <= a;
                  b_sr_q  <= b;
                  carry_q <= c_in;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_sr_q   <= a_sr_q >> 1;
               b_sr_q   <= b_sr_q >> 1;
               res_sr_q <= res_d;
               carry_q  <= fa_cout;
               cnt_q    <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  sum_q   <= res_d;
                  c_out_q <= fa_cout;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;
   assign c_out     = c_out_q;
   assign dbg_state = state_q;

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-multiplexes one existing full_adder cell to add two WIDTH-bit operands plus carry-in over WIDTH clock cycles.
- Sits beside the 8-bit ripple adder as the area-minimal alternative.
- Owns operand shift registers, carry register, bit counter and the start/busy/done handshake.

Parameters:
- WIDTH, 8, operand width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deassertion synchronous to clk.
- start  input  1  request; sampled on rising edge when state is IDLE or DONE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- c_in  input  1  carry-in; captured on accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; registered, held until the next completion.
- c_out  output  1  carry-out; registered, held with sum.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE; counter=0; shift registers=0; carry reg=0.
  - busy=0, done=0, sum=0, c_out=0.
  - Reset mid-RUN abandons the operation: no done pulse, sum/c_out cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: load a_sr<=a, b_sr<=b, carry<=c_in, cnt<=0; go to RUN.
  - start=0: stay in IDLE.
- RUN:
  - Full_adder inputs are a_sr[0], b_sr[0], carry.
  - Each edge: a_sr and b_sr shift right by one; Sum is shifted into res_sr MSB (right shift); carry<=C_out; cnt<=cnt+1.
  - When cnt==WIDTH-1 at the edge: sum<=final res_sr, c_out<=C_out; go to DONE.
  - start is ignored in RUN; no error flag.
  - The sum/c_out outputs are not disturbed during RUN; they keep the previous result.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back op); next state RUN.
  - Otherwise next state IDLE.
- Latency: start sampled at E0 -> done high in the cycle after edge E(WIDTH). Throughput is one op per WIDTH+1 cycles.
- busy is high from the cycle after E0 through the cycle of E(WIDTH).
- Arithmetic: {c_out,sum} = a + b + c_in, modulo 2^(WIDTH+1); no overflow flag.
- WIDTH=1: RUN lasts one cycle; sum = a^b^c_in.
- Operand inputs may change freely after the accepting edge; only captured values are used.
- Counter never wraps: RUN exits at WIDTH-1.
- All outputs are registered; no combinational path from start to busy or done.

Decomposition:
- Shared package add_pkg:
  - State encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Default WIDTH constant shared with the ripple adder bench.
- One sub-module: the existing full_adder (ports A, B, C_in, Sum, C_out), instantiated once.
- Everything else is in-line: FSM, counter, shift registers.

Test Plan:
- Reset, then a=8'h00, b=8'h00, c_in=0, start pulse -> busy for 8 cycles; done in the 9th cycle after the start edge; sum=8'h00, c_out=0.
- a=8'hFF, b=8'h01, c_in=0 -> sum=8'h00, c_out=1; a=8'h7F, b=8'h01 -> sum=8'h80, c_out=0; a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1.
- Start with 8'h12+8'h34, then pulse start with 8'hFF+8'hFF at RUN cycle 3 -> second request ignored; result 8'h46, c_out=0; exactly one done.
- Start held high continuously with new operands each accept -> ops accepted at the DONE cycles; done every 9 cycles; each result correct; sum stable between dones.
- 8'hF0+8'h0F in flight, rst_n low at RUN cycle 5 (asynchronous, mid-cycle) -> busy, done, sum, c_out go to 0 before the next edge; no done after release; next op computes correctly.
- WIDTH=4 build, exhaustive 512 combinations of a, b, c_in against the a+b+c_in model -> zero mismatches; done exactly 5 cycles after each start edge.
